// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle LEGv8 controller.
package multicycle_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  // CBZ matches on the upper eight bits only
  localparam logic [7:0]  OpCbzPrefix = 8'b10110100;

  localparam logic [3:0] AluAnd   = 4'b0000;
  localparam logic [3:0] AluOrr   = 4'b0001;
  localparam logic [3:0] AluAdd   = 4'b0010;
  localparam logic [3:0] AluSub   = 4'b0110;
  localparam logic [3:0] AluPassB = 4'b0111;

  localparam logic [1:0] ErrNone      = 2'b00;
  localparam logic [1:0] ErrIllegal   = 2'b01;
  localparam logic [1:0] ErrImTimeout = 2'b10;
  localparam logic [1:0] ErrDmTimeout = 2'b11;

endpackage

// File: rtl/multicycle_controller_op_decoder.sv
// Combinational classification of the latched opcode and its ALU operation.
module op_decoder
  import multicycle_pkg::*;
(
  input  logic [10:0] op_i,
  output logic        legal_o,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        is_cbz_o,
  output logic        is_rtype_o,
  output logic [3:0]  alu_ctl_o
);

  always_comb begin
    is_load_o  = (op_i == OpLdur);
    is_store_o = (op_i == OpStur);
    is_cbz_o   = (op_i[10:3] == OpCbzPrefix);
    is_rtype_o = (op_i == OpAdd) || (op_i == OpSub) || (op_i == OpAnd) || (op_i == OpOrr);
    legal_o    = is_load_o | is_store_o | is_cbz_o | is_rtype_o;

    alu_ctl_o = AluAdd;
    if (is_cbz_o) begin
      alu_ctl_o = AluPassB;
    end else begin
      case (op_i)
        OpSub:   alu_ctl_o = AluSub;
        OpAnd:   alu_ctl_o = AluAnd;
        OpOrr:   alu_ctl_o = AluOrr;
        default: alu_ctl_o = AluAdd;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle LEGv8 control FSM with req/ready memory handshakes and wait timeouts.
// Define MULTICYCLE_PERF_CNT_EN to add the cycle_cnt/retired_cnt performance counters.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W   = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        im_ready,
  input  logic        dm_ready,
  output logic        im_req,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        PCSrc,
  output logic        reg2loc,
  output logic        AluSrc,
  output logic [3:0]  AluControl,
  output logic        Branch,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic        memtoReg,
  output logic        halted,
  output logic [1:0]  err_code
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
`endif
);

  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] LastWait = WaitW'(TIMEOUT - 1);

  state_e           state_q;
  logic [10:0]      op_q;
  logic [WaitW-1:0] wait_q;
  logic [1:0]       err_q;

  logic       legal;
  logic       is_load;
  logic       is_store;
  logic       is_cbz;
  logic       is_rtype;
  logic [3:0] alu_ctl;

  op_decoder u_op_decoder (
    .op_i       (op_q),
    .legal_o    (legal),
    .is_load_o  (is_load),
    .is_store_o (is_store),
    .is_cbz_o   (is_cbz),
    .is_rtype_o (is_rtype),
    .alu_ctl_o  (alu_ctl)
  );

  // wait_q is zero on every entry to FETCH/MEM because all exits clear it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      wait_q  <= '0;
      err_q   <= ErrNone;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StFetch;
        end
        StFetch: begin
          if (im_ready) begin
            op_q    <= opcode;
            wait_q  <= '0;
            state_q <= StDecode;
          end else if (wait_q == LastWait) begin
            wait_q  <= '0;
            err_q   <= ErrImTimeout;
            state_q <= StHalt;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StDecode: begin
          if (!legal) begin
            err_q   <= ErrIllegal;
            state_q <= StHalt;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          wait_q <= '0;
          if (is_cbz) begin
            state_q <= StFetch;
          end else if (is_rtype) begin
            state_q <= StWb;
          end else begin
            state_q <= StMem;
          end
        end
        StMem: begin
          if (dm_ready) begin
            wait_q  <= '0;
            state_q <= is_load ? StWb : StFetch;
          end else if (wait_q == LastWait) begin
            wait_q  <= '0;
            err_q   <= ErrDmTimeout;
            state_q <= StHalt;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StWb: begin
          state_q <= StFetch;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StHalt;
        end
      endcase
    end
  end

  // Decoded from state_q/op_q; handshake strobes are qualified by ready in the same cycle
  always_comb begin
    im_req     = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    PCSrc      = 1'b0;
    reg2loc    = 1'b0;
    AluSrc     = 1'b0;
    AluControl = 4'b0000;
    Branch     = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    memtoReg   = 1'b0;
    halted     = (state_q == StHalt);
    err_code   = err_q;
    case (state_q)
      StFetch: begin
        im_req  = 1'b1;
        irWrite = im_ready;
      end
      StDecode: begin
        reg2loc = is_store | is_cbz;
      end
      StExec: begin
        reg2loc    = is_store | is_cbz;
        AluSrc     = is_load | is_store;
        AluControl = alu_ctl;
        if (is_cbz) begin
          Branch  = 1'b1;
          pcWrite = 1'b1;
          PCSrc   = zero;
        end
      end
      StMem: begin
        reg2loc    = is_store;
        AluSrc     = 1'b1;
        AluControl = alu_ctl;
        memRead    = is_load;
        memWrite   = is_store;
        pcWrite    = is_store & dm_ready;
      end
      StWb: begin
        regWrite = 1'b1;
        memtoReg = is_load;
        pcWrite  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      if (state_q != StIdle && state_q != StHalt) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (pcWrite) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;
`endif

endmodule
